// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-port memory between an instruction-fetch
// requester and a data requester. Each access takes 3 cycles: grant, issue, then response.
module mem_arbiter #(
    parameter int MEM_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 instr_req,
    input  logic [MEM_WIDTH-1:0] instr_addr,
    output logic                 instr_ack,
    output logic [MEM_WIDTH-1:0] instr_rdata,
    input  logic                 data_req,
    input  logic                 data_we,
    input  logic [MEM_WIDTH-1:0] data_addr,
    input  logic [MEM_WIDTH-1:0] data_wdata,
    output logic                 data_ack,
    output logic [MEM_WIDTH-1:0] data_rdata,
    output logic [MEM_WIDTH-1:0] mem_addr,
    output logic                 mem_read_en,
    output logic                 mem_write_en,
    output logic [MEM_WIDTH-1:0] mem_write_val,
    input  logic [MEM_WIDTH-1:0] mem_read_val,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   last_grant;   // 1: data was granted most recently
    logic                   win_q;        // 1: current transaction belongs to data
    logic                   we_q;
    logic [MEM_WIDTH-1:0]   addr_q;
    logic [MEM_WIDTH-1:0]   wdata_q;
    logic                   instr_elig;
    logic                   data_elig;
    logic                   grant;
    logic                   grant_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        grant         = 1'b0;
        // A requester whose ack is high is still holding req from the finished access.
        instr_elig    = instr_req & ~instr_ack;
        data_elig     = data_req & ~data_ack;
        grant_data    = data_elig & (~instr_elig | ~last_grant);
        mem_read_en   = 1'b0;
        mem_write_en  = 1'b0;
        mem_addr      = addr_q;
        mem_write_val = wdata_q;
        busy          = (state != IDLE);
        case (state)
            IDLE: begin
                if (instr_elig || data_elig) begin
                    grant      = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_read_en  = ~we_q;
                mem_write_en = we_q;
                state_next   = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant  <= 1'b0;
            win_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            instr_ack   <= 1'b0;
            data_ack    <= 1'b0;
            instr_rdata <= '0;
            data_rdata  <= '0;
        end else begin
            instr_ack <= 1'b0;
            data_ack  <= 1'b0;
            if (grant) begin
                win_q      <= grant_data;
                last_grant <= grant_data;
                we_q       <= grant_data & data_we;
                addr_q     <= grant_data ? data_addr : instr_addr;
                if (grant_data) begin
                    wdata_q <= data_wdata;
                end
            end
            if (state == RESP) begin
                if (win_q) begin
                    data_ack <= 1'b1;
                    if (!we_q) begin
                        data_rdata <= mem_read_val;
                    end
                end else begin
                    instr_ack   <= 1'b1;
                    instr_rdata <= mem_read_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic scored against a
// transaction-level schedule and memory model.
module tb_mem_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         instr_req;
    logic [W-1:0] instr_addr;
    logic         instr_ack;
    logic [W-1:0] instr_rdata;
    logic         data_req;
    logic         data_we;
    logic [W-1:0] data_addr;
    logic [W-1:0] data_wdata;
    logic         data_ack;
    logic [W-1:0] data_rdata;
    logic [W-1:0] mem_addr;
    logic         mem_read_en;
    logic         mem_write_en;
    logic [W-1:0] mem_write_val;
    logic [W-1:0] mem_read_val;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] env_mem [64];
    logic         mem_load;

    mem_arbiter #(.MEM_WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_req    (instr_req),
        .instr_addr   (instr_addr),
        .instr_ack    (instr_ack),
        .instr_rdata  (instr_rdata),
        .data_req     (data_req),
        .data_we      (data_we),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_ack     (data_ack),
        .data_rdata   (data_rdata),
        .mem_addr     (mem_addr),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_write_val(mem_write_val),
        .mem_read_val (mem_read_val),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] init_word(int unsigned i);
        logic [W-1:0] v;
        v = 32'hA5000000 | (i * 32'h00010203);
        if (i == 4) v = 32'h2402000A;
        return v;
    endfunction

    // Memory with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) env_mem[i] <= init_word(i);
        end else if (mem_write_en) begin
            env_mem[mem_addr[7:2]] <= mem_write_val;
        end
        if (mem_read_en) mem_read_val <= env_mem[mem_addr[7:2]];
    end

    function automatic logic [W-1:0] rand_addr();
        logic [5:0] idx;
        idx = 6'($urandom_range(0, 63));
        return {24'h0, idx, 2'b00};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; mem_load = 1'b1;
        instr_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
        tick(); tick();
        reset = 1'b0; mem_load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_load = 1'b1;
        instr_req = 1'b1; data_req = 1'b1; data_we = 1'b1;
        instr_addr = 32'h44; data_addr = 32'h48; data_wdata = 32'h1234_5678;
        tick(); tick();
        checks++; if (instr_ack !== 1'b0) begin errors++; $display("FAIL rst_instr_ack got %b exp 0", instr_ack); end
        checks++; if (data_ack !== 1'b0) begin errors++; $display("FAIL rst_data_ack got %b exp 0", data_ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (mem_read_en !== 1'b0) begin errors++; $display("FAIL rst_read_en got %b exp 0", mem_read_en); end
        checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL rst_write_en got %b exp 0", mem_write_en); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
        checks++; if (mem_write_val !== 32'h0) begin errors++; $display("FAIL rst_write_val got %h exp 0", mem_write_val); end
        checks++; if (instr_rdata !== 32'h0) begin errors++; $display("FAIL rst_instr_rdata got %h exp 0", instr_rdata); end
        checks++; if (data_rdata !== 32'h0) begin errors++; $display("FAIL rst_data_rdata got %h exp 0", data_rdata); end
        instr_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
        reset = 1'b0; mem_load = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        instr_req = 1'b1; instr_addr = 32'h10;
        tick();
        checks++; if (mem_read_en !== 1'b1) begin errors++; $display("FAIL fetch_read_en got %b exp 1", mem_read_en); end
        checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL fetch_write_en got %b exp 0", mem_write_en); end
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL fetch_mem_addr got %h exp 10", mem_addr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fetch_busy got %b exp 1", busy); end
        tick();
        checks++; if (instr_ack !== 1'b0 || mem_read_en !== 1'b0) begin errors++; $display("FAIL fetch_early got ack=%b rd=%b exp 0 0", instr_ack, mem_read_en); end
        tick();
        checks++; if (instr_ack !== 1'b1) begin errors++; $display("FAIL fetch_ack got %b exp 1", instr_ack); end
        checks++; if (instr_rdata !== 32'h2402000A) begin errors++; $display("FAIL fetch_rdata got %h exp 2402000a", instr_rdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fetch_idle got %b exp 0", busy); end
        instr_req = 1'b0;
        tick();
        checks++; if (instr_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fetch_after got ack=%b busy=%b exp 0 0", instr_ack, busy); end
    endtask

    task automatic test_write_read();
        logic [W-1:0] prev;
        prev = data_rdata;
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h20; data_wdata = 32'hDEADBEEF;
        tick();
        checks++; if (mem_write_en !== 1'b1 || mem_read_en !== 1'b0) begin errors++; $display("FAIL wr_strobe got wr=%b rd=%b exp 1 0", mem_write_en, mem_read_en); end
        checks++; if (mem_addr !== 32'h20) begin errors++; $display("FAIL wr_addr got %h exp 20", mem_addr); end
        checks++; if (mem_write_val !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_val got %h exp deadbeef", mem_write_val); end
        tick();
        checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL wr_single got %b exp 0", mem_write_en); end
        tick();
        checks++; if (data_ack !== 1'b1) begin errors++; $display("FAIL wr_ack got %b exp 1", data_ack); end
        checks++; if (data_rdata !== prev) begin errors++; $display("FAIL wr_rdata_kept got %h exp %h", data_rdata, prev); end
        data_we = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || data_ack !== 1'b0) begin errors++; $display("FAIL held_req_regrant got busy=%b ack=%b exp 0 0", busy, data_ack); end
        tick();
        checks++; if (mem_read_en !== 1'b1 || mem_addr !== 32'h20) begin errors++; $display("FAIL rd_strobe got rd=%b addr=%h exp 1 20", mem_read_en, mem_addr); end
        tick(); tick();
        checks++; if (data_ack !== 1'b1 || data_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_back got ack=%b data=%h exp 1 deadbeef", data_ack, data_rdata); end
        data_req = 1'b0;
        tick();
    endtask

    task automatic test_input_change();
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h20;
        tick();
        checks++; if (mem_addr !== 32'h20 || mem_read_en !== 1'b1) begin errors++; $display("FAIL chg_issue got addr=%h rd=%b exp 20 1", mem_addr, mem_read_en); end
        data_addr = 32'h40; data_we = 1'b1;
        tick();
        checks++; if (mem_addr !== 32'h20) begin errors++; $display("FAIL chg_hold got %h exp 20", mem_addr); end
        tick();
        checks++; if (data_ack !== 1'b1 || data_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL chg_ack got ack=%b data=%h exp 1 deadbeef", data_ack, data_rdata); end
        data_req = 1'b0; data_we = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        do_reset();
        instr_req = 1'b1; instr_addr = 32'h30;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h34;
        for (int k = 1; k <= 12; k++) begin
            logic ed, ei;
            tick();
            ed = (k == 3 || k == 9);
            ei = (k == 6 || k == 12);
            checks++; if (data_ack !== ed || instr_ack !== ei) begin
                errors++; $display("FAIL contention_k%0d got d=%b i=%b exp d=%b i=%b", k, data_ack, instr_ack, ed, ei);
            end
        end
        checks++; if (instr_rdata !== init_word(12) || data_rdata !== init_word(13)) begin
            errors++; $display("FAIL contention_data got %h %h exp %h %h", instr_rdata, data_rdata, init_word(12), init_word(13));
        end
        instr_req = 1'b0; data_req = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset_in_resp();
        instr_req = 1'b1; instr_addr = 32'h10;
        tick(); tick();
        reset = 1'b1;
        tick();
        checks++; if (instr_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rr_abort got ack=%b busy=%b exp 0 0", instr_ack, busy); end
        checks++; if (instr_rdata !== 32'h0) begin errors++; $display("FAIL rr_rdata got %h exp 0", instr_rdata); end
        reset = 1'b0;
        tick();
        checks++; if (mem_read_en !== 1'b1 || mem_addr !== 32'h10) begin errors++; $display("FAIL rr_regrant got rd=%b addr=%h exp 1 10", mem_read_en, mem_addr); end
        tick();
        checks++; if (instr_ack !== 1'b0) begin errors++; $display("FAIL rr_early got %b exp 0", instr_ack); end
        tick();
        checks++; if (instr_ack !== 1'b1 || instr_rdata !== 32'h2402000A) begin errors++; $display("FAIL rr_ack got ack=%b data=%h exp 1 2402000a", instr_ack, instr_rdata); end
        instr_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int unsigned  g_cyc = 0;
        bit           active = 0, win = 0, g_we = 0, last = 0;
        bit           e_ack_i, e_ack_d, e_strobe, e_busy, ei, ed;
        logic [W-1:0] g_addr = '0, g_wdata = '0, g_rdata = '0;
        logic [W-1:0] exp_ir = '0, exp_dr = '0;
        logic [W-1:0] ref_mem [64];
        do_reset();
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        for (int unsigned c = 0; c < 600; c++) begin
            e_strobe = active && (c == g_cyc + 1);
            e_busy   = active && (c == g_cyc + 1 || c == g_cyc + 2);
            e_ack_i  = active && !win && (c == g_cyc + 3);
            e_ack_d  = active && win && (c == g_cyc + 3);
            if (e_ack_i) exp_ir = g_rdata;
            if (e_ack_d && !g_we) exp_dr = g_rdata;
            checks++; if (instr_ack !== e_ack_i || data_ack !== e_ack_d) begin
                errors++; $display("FAIL rnd_ack c%0d got i=%b d=%b exp i=%b d=%b", c, instr_ack, data_ack, e_ack_i, e_ack_d);
            end
            checks++; if (mem_read_en !== (e_strobe && !g_we) || mem_write_en !== (e_strobe && g_we)) begin
                errors++; $display("FAIL rnd_strobe c%0d got rd=%b wr=%b exp rd=%b wr=%b", c, mem_read_en, mem_write_en, e_strobe && !g_we, e_strobe && g_we);
            end
            checks++; if (busy !== e_busy) begin errors++; $display("FAIL rnd_busy c%0d got %b exp %b", c, busy, e_busy); end
            checks++; if (instr_rdata !== exp_ir || data_rdata !== exp_dr) begin
                errors++; $display("FAIL rnd_rdata c%0d got %h %h exp %h %h", c, instr_rdata, data_rdata, exp_ir, exp_dr);
            end
            if (e_strobe) begin
                checks++; if (mem_addr !== g_addr) begin errors++; $display("FAIL rnd_addr c%0d got %h exp %h", c, mem_addr, g_addr); end
                if (g_we) begin
                    checks++; if (mem_write_val !== g_wdata) begin errors++; $display("FAIL rnd_wval c%0d got %h exp %h", c, mem_write_val, g_wdata); end
                end
            end
            if (active && c == g_cyc + 3) active = 0;

            if (e_ack_i) begin
                instr_req = 1'($urandom_range(0, 1)); instr_addr = rand_addr();
            end else if (instr_req && active && !win) begin
                if ($urandom_range(0, 1) == 0) instr_addr = rand_addr();
            end else if (instr_req) begin
                if ($urandom_range(0, 7) == 0) instr_req = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                instr_req = 1'b1; instr_addr = rand_addr();
            end
            if (e_ack_d) begin
                data_req = 1'($urandom_range(0, 1)); data_addr = rand_addr();
                data_we = 1'($urandom_range(0, 1)); data_wdata = $urandom;
            end else if (data_req && active && win) begin
                if ($urandom_range(0, 1) == 0) begin
                    data_addr = rand_addr(); data_we = ~data_we; data_wdata = $urandom;
                end
            end else if (data_req) begin
                if ($urandom_range(0, 7) == 0) data_req = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                data_req = 1'b1; data_addr = rand_addr();
                data_we = 1'($urandom_range(0, 1)); data_wdata = $urandom;
            end

            if (!active) begin
                ei = instr_req && !e_ack_i;
                ed = data_req && !e_ack_d;
                if (ei || ed) begin
                    win    = ed && (!ei || !last);
                    last   = win;
                    active = 1;
                    g_cyc  = c;
                    g_addr = win ? data_addr : instr_addr;
                    g_we   = win && data_we;
                    if (win) g_wdata = data_wdata;
                    if (g_we) ref_mem[g_addr[7:2]] = g_wdata;
                    else      g_rdata = ref_mem[g_addr[7:2]];
                end
            end
            tick();
        end
        instr_req = 1'b0; data_req = 1'b0;
        tick(); tick(); tick();
    endtask

    initial begin
        reset = 1'b1; mem_load = 1'b0;
        instr_req = 1'b0; instr_addr = '0;
        data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
        test_reset();
        test_fetch();
        test_write_read();
        test_input_change();
        test_contention();
        test_reset_in_resp();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
